wireframe_sequencer: RTL and testbench

- Command front-end for the Bresenham line drawer.
- Accepts line or triangle commands through a valid/ready port and buffers them in a small FIFO.
- Splits triangles into three edges, drops zero-length edges (the drawer cannot terminate on them) and sequences the drawer's level-sensitive start/busy handshake one edge at a time.
- Sits between the AXI-lite command registers and the line drawer.

---
 rtl/wireframe_sequencer.sv | 155 +++++++++++++++
 tb/tb_wireframe_sequencer.sv | 289 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/wireframe_sequencer.sv
// wireframe_sequencer: command FIFO + edge sequencer in front of the Bresenham line drawer.
// Ports: clk/rst (async, active-high); cmd_valid/cmd_ready/cmd_mode/cmd_data command input
// ({v2y,v2x,v1y,v1x,v0y,v0x}); flush drops queued work; drw_* endpoints and drw_start/drw_busy
// drawer handshake; busy, fifo_level, edges_drawn, edges_skipped, timeouts status.
module wireframe_sequencer #(
    parameter int FIFO_DEPTH  = 4,
    parameter int ACK_TIMEOUT = 256,
    parameter int START_GAP   = 2
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          cmd_valid,
    output logic                          cmd_ready,
    input  logic                          cmd_mode,
    input  logic [95:0]                   cmd_data,
    input  logic                          flush,
    output logic [15:0]                   drw_x0,
    output logic [15:0]                   drw_y0,
    output logic [15:0]                   drw_x1,
    output logic [15:0]                   drw_y1,
    output logic                          drw_start,
    input  logic                          drw_busy,
    output logic                          busy,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
    output logic [31:0]                   edges_drawn,
    output logic [15:0]                   edges_skipped,
    output logic [15:0]                   timeouts
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int TW = $clog2(ACK_TIMEOUT + 1);
    localparam int GW = $clog2(START_GAP + 1);

    typedef enum logic [2:0] {IDLE, LOAD, EDGE, ISSUE, WAIT_ACK, WAIT_DONE, GAP} state_t;

    state_t        state_q;
    logic [96:0]   mem_q [FIFO_DEPTH];
    logic [AW-1:0] wr_q, rd_q;
    logic [AW:0]   cnt_q;
    logic [96:0]   work_q;
    logic [1:0]    idx_q, ecnt_q;
    logic          seen_q;
    logic [TW-1:0] tmr_q;
    logic [GW-1:0] gap_q;
    logic          push, pop, last;
    logic [15:0]   ex0, ey0, ex1, ey1;

    always_comb begin
        cmd_ready  = cnt_q != (AW+1)'(FIFO_DEPTH);
        fifo_level = cnt_q;
        push       = cmd_valid & cmd_ready & ~flush;
        pop        = state_q == IDLE && cnt_q != '0 && !flush;
        // a flush in the current cycle ends the command just like one seen earlier
        last       = idx_q + 2'd1 == ecnt_q || seen_q || flush;
        ex0 = idx_q == 2'd0 ? work_q[15:0]  : idx_q == 2'd1 ? work_q[47:32] : work_q[79:64];
        ey0 = idx_q == 2'd0 ? work_q[31:16] : idx_q == 2'd1 ? work_q[63:48] : work_q[95:80];
        ex1 = idx_q == 2'd0 ? work_q[47:32] : idx_q == 2'd1 ? work_q[79:64] : work_q[15:0];
        ey1 = idx_q == 2'd0 ? work_q[63:48] : idx_q == 2'd1 ? work_q[95:80] : work_q[31:16];
    end

    always_ff @(posedge clk) begin
        if (push) mem_q[wr_q] <= {cmd_mode, cmd_data};
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
        end else if (flush) begin
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
        end else begin
            if (push) wr_q <= wr_q + 1'b1;
            if (pop) rd_q <= rd_q + 1'b1;
            cnt_q <= cnt_q + (AW+1)'(push) - (AW+1)'(pop);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= IDLE;
            work_q        <= '0;
            idx_q         <= '0;
            ecnt_q        <= '0;
            seen_q        <= 1'b0;
            tmr_q         <= '0;
            gap_q         <= '0;
            drw_x0        <= '0;
            drw_y0        <= '0;
            drw_x1        <= '0;
            drw_y1        <= '0;
            drw_start     <= 1'b0;
            busy          <= 1'b0;
            edges_drawn   <= '0;
            edges_skipped <= '0;
            timeouts      <= '0;
        end else begin
            busy <= push || cnt_q != '0 || state_q != IDLE;
            if (flush && state_q != IDLE) seen_q <= 1'b1;
            case (state_q)
                IDLE: if (pop) begin
                    work_q  <= mem_q[rd_q];
                    seen_q  <= 1'b0;
                    state_q <= LOAD;
                end
                LOAD: begin
                    idx_q   <= '0;
                    ecnt_q  <= work_q[96] ? 2'd3 : 2'd1;
                    state_q <= EDGE;
                end
                EDGE: if (ex0 == ex1 && ey0 == ey1) begin
                    // zero-length edges would never terminate in the drawer
                    edges_skipped <= edges_skipped + 16'd1;
                    idx_q         <= idx_q + 2'd1;
                    state_q       <= last ? IDLE : EDGE;
                end else begin
                    drw_x0  <= ex0;
                    drw_y0  <= ey0;
                    drw_x1  <= ex1;
                    drw_y1  <= ey1;
                    state_q <= ISSUE;
                end
                ISSUE: begin
                    drw_start <= 1'b1;
                    tmr_q     <= '0;
                    state_q   <= WAIT_ACK;
                end
                WAIT_ACK: if (drw_busy) begin
                    drw_start <= 1'b0;
                    state_q   <= WAIT_DONE;
                end else if (tmr_q == TW'(ACK_TIMEOUT - 1)) begin
                    drw_start <= 1'b0;
                    timeouts  <= timeouts + {15'd0, timeouts != 16'hFFFF};
                    gap_q     <= '0;
                    state_q   <= GAP;
                end else begin
                    tmr_q <= tmr_q + 1'b1;
                end
                WAIT_DONE: if (!drw_busy) begin
                    edges_drawn <= edges_drawn + 32'd1;
                    gap_q       <= '0;
                    state_q     <= GAP;
                end
                GAP: if (gap_q == GW'(START_GAP - 1)) begin
                    idx_q   <= idx_q + 2'd1;
                    state_q <= last ? IDLE : EDGE;
                end else begin
                    gap_q <= gap_q + 1'b1;
                end
                default: state_q <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_wireframe_sequencer.sv
// tb_wireframe_sequencer: scoreboard bench with a drawer model for wireframe_sequencer.
module tb_wireframe_sequencer;
    localparam int FIFO_DEPTH  = 4;
    localparam int ACK_TIMEOUT = 256;
    localparam int START_GAP   = 2;

    logic        clk, rst, cmd_valid, cmd_ready, cmd_mode, flush, drw_start, drw_busy, busy;
    logic [95:0] cmd_data;
    logic [15:0] drw_x0, drw_y0, drw_x1, drw_y1, edges_skipped, timeouts;
    logic [2:0]  fifo_level;
    logic [31:0] edges_drawn;

    wireframe_sequencer #(.FIFO_DEPTH(FIFO_DEPTH), .ACK_TIMEOUT(ACK_TIMEOUT), .START_GAP(START_GAP)) dut (
        .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_mode(cmd_mode),
        .cmd_data(cmd_data), .flush(flush), .drw_x0(drw_x0), .drw_y0(drw_y0), .drw_x1(drw_x1),
        .drw_y1(drw_y1), .drw_start(drw_start), .drw_busy(drw_busy), .busy(busy),
        .fifo_level(fifo_level), .edges_drawn(edges_drawn), .edges_skipped(edges_skipped),
        .timeouts(timeouts)
    );

    typedef struct {bit tmo; logic [63:0] c;} ent_t;

    ent_t sb[$];
    ent_t cur;
    int   checks = 0, errors = 0;
    int   exp_drawn = 0, exp_skip = 0, exp_tmo = 0;
    int   ack_cfg = 0, len_cfg = 0, max_level = 0;
    bit   noack = 0, stall = 0, in_edge = 0;

    initial begin
        clk = 0;
        forever #5 clk = ~clk;
    end

    initial begin
        #900000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    task automatic chk_eq(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, required %0h", name, act, exp);
        end
    endtask

    function automatic logic [95:0] pk(int x0, int y0, int x1, int y1, int x2, int y2);
        return {16'(y2), 16'(x2), 16'(y1), 16'(x1), 16'(y0), 16'(x0)};
    endfunction

    // reference: split into edges, drop the zero-length ones, predict counters
    task automatic model_cmd(input logic m, input logic [95:0] d, input bit tmo);
        logic [15:0] vx[3], vy[3];
        ent_t e;
        for (int i = 0; i < 3; i++) begin
            vx[i] = d[32*i +: 16];
            vy[i] = d[32*i+16 +: 16];
        end
        for (int k = 0; k < (m ? 3 : 1); k++) begin
            int b = (k + 1) % 3;
            if (vx[k] == vx[b] && vy[k] == vy[b]) exp_skip++;
            else begin
                e.tmo = tmo;
                e.c = {vx[k], vy[k], vx[b], vy[b]};
                sb.push_back(e);
                if (tmo) exp_tmo++;
                else exp_drawn++;
            end
        end
    endtask

    task automatic push_cmd(input logic m, input logic [95:0] d, input bit tmo);
        int n = 0;
        model_cmd(m, d, tmo);
        cmd_mode = m;
        cmd_data = d;
        cmd_valid = 1;
        while (!cmd_ready && n < 3000) begin
            @(negedge clk);
            n++;
        end
        if (n >= 3000) begin
            checks++;
            errors++;
            $display("FAIL push_timeout: got cmd_ready=0, required 1");
        end
        @(negedge clk);
        cmd_valid = 0;
    endtask

    task automatic wait_idle();
        int n = 0;
        while ((busy || drw_busy || sb.size() != 0) && n < 5000) begin
            @(negedge clk);
            n++;
        end
        if (n >= 5000) begin
            checks++;
            errors++;
            $display("FAIL idle_timeout: got busy=%0d pending=%0d, required 0/0", busy, sb.size());
        end
        repeat (3) @(negedge clk);
    endtask

    task automatic check_counts();
        chk_eq("edges_drawn", edges_drawn, exp_drawn);
        chk_eq("edges_skipped", edges_skipped, exp_skip);
        chk_eq("timeouts", timeouts, exp_tmo);
        chk_eq("busy_idle", busy, 0);
        chk_eq("fifo_level_idle", fifo_level, 0);
    endtask

    // drawer model: acks a start after a delay, stays busy for a line length (longer while stalled)
    initial begin
        drw_busy = 0;
        forever begin
            @(negedge clk);
            if (drw_start && !noack && !drw_busy) begin
                int ad = ack_cfg != 0 ? ack_cfg : int'($urandom_range(1, 4));
                int ln = len_cfg != 0 ? len_cfg : int'($urandom_range(1, 10));
                repeat (ad) @(negedge clk);
                drw_busy = 1;
                repeat (ln) @(negedge clk);
                while (stall) @(negedge clk);
                drw_busy = 0;
            end
        end
    end

    // monitor: every start rise must match the next predicted edge
    initial begin
        bit prev = 0, have_prev = 0;
        int hi_cnt = 0, gap_cnt = 0;
        cur.tmo = 0;
        cur.c = '0;
        forever begin
            @(posedge clk);
            #1;
            if (rst) begin
                in_edge = 0;
                prev = 0;
                have_prev = 0;
            end else begin
                if (int'(fifo_level) > max_level) max_level = int'(fifo_level);
                if (drw_start && !prev) begin
                    if (have_prev) begin
                        checks++;
                        if (gap_cnt < START_GAP) begin
                            errors++;
                            $display("FAIL start_gap: got %0d low cycles, required >= %0d", gap_cnt, START_GAP);
                        end
                    end
                    if (sb.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_start: got start with coords %0h, required none", {drw_x0, drw_y0, drw_x1, drw_y1});
                    end else begin
                        cur = sb.pop_front();
                        chk_eq("edge_coords", {drw_x0, drw_y0, drw_x1, drw_y1}, cur.c);
                        in_edge = 1;
                    end
                    hi_cnt = 0;
                end
                if (!drw_start && prev) begin
                    have_prev = 1;
                    gap_cnt = 0;
                    if (cur.tmo) chk_eq("start_hold", 64'(hi_cnt), 64'(ACK_TIMEOUT));
                end
                if (drw_start) hi_cnt++;
                else gap_cnt++;
                if (in_edge && (drw_start || drw_busy))
                    chk_eq("coord_stable", {drw_x0, drw_y0, drw_x1, drw_y1}, cur.c);
                prev = drw_start;
            end
        end
    end

    initial begin
        int n;
        rst = 0;
        cmd_valid = 0;
        cmd_mode = 0;
        cmd_data = '0;
        flush = 0;
        #1 rst = 1;
        #5;
        chk_eq("reset_outputs", {drw_start, busy, fifo_level, drw_x0, drw_y0, drw_x1, drw_y1}, 0);
        chk_eq("reset_counters", {edges_drawn, edges_skipped, timeouts}, 0);
        chk_eq("reset_ready", cmd_ready, 1);
        @(negedge clk);
        rst = 0;
        repeat (2) @(negedge clk);

        // single line with a fixed drawer timing
        ack_cfg = 3;
        len_cfg = 31;
        push_cmd(0, pk(10, 20, 40, 25, 0, 0), 0);
        chk_eq("busy_after_push", busy, 1);
        wait_idle();
        chk_eq("line_coords", {drw_x0, drw_y0, drw_x1, drw_y1}, {16'd10, 16'd20, 16'd40, 16'd25});
        check_counts();
        ack_cfg = 0;
        len_cfg = 0;

        // triangle, then triangle with a degenerate first edge
        push_cmd(1, pk(0, 0, 8, 0, 0, 8), 0);
        wait_idle();
        check_counts();
        push_cmd(1, pk(5, 5, 5, 5, 9, 1), 0);
        wait_idle();
        check_counts();

        // drawer never acknowledges: every edge times out
        noack = 1;
        push_cmd(1, pk(0, 0, 100, 0, 0, 100), 1);
        wait_idle();
        check_counts();
        noack = 0;

        // fill the FIFO while the drawer is stuck on the first edge
        stall = 1;
        max_level = 0;
        for (int i = 1; i <= 5; i++) push_cmd(0, pk(i * 10, i, i * 10 + 5, i + 7, 0, 0), 0);
        chk_eq("ready_full", cmd_ready, 0);
        chk_eq("level_full", fifo_level, FIFO_DEPTH);
        repeat (20) @(negedge clk);
        stall = 0;
        wait_idle();
        chk_eq("max_level", 64'(max_level), FIFO_DEPTH);
        check_counts();

        // flush while the first edge of the first triangle is in flight
        push_cmd(1, pk(1, 1, 30, 2, 4, 20), 0);
        push_cmd(1, pk(2, 2, 31, 3, 5, 21), 0);
        push_cmd(1, pk(3, 3, 32, 4, 6, 22), 0);
        n = 0;
        while (!drw_busy && n < 500) begin
            @(negedge clk);
            n++;
        end
        chk_eq("flush_edge_started", drw_busy, 1);
        flush = 1;
        exp_drawn -= sb.size();
        sb.delete();
        @(negedge clk);
        flush = 0;
        chk_eq("flush_level", fifo_level, 0);
        wait_idle();
        check_counts();

        // randomized commands with small coordinates so degenerate edges occur
        for (int i = 0; i < 24; i++) begin
            logic m = 1'($urandom_range(0, 1));
            push_cmd(m, pk($urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3),
                           $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3)), 0);
            if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 10)) @(negedge clk);
        end
        wait_idle();
        check_counts();

        // asynchronous reset in the middle of an edge
        push_cmd(0, pk(7, 7, 50, 60, 0, 0), 0);
        n = 0;
        while (!drw_start && n < 500) begin
            @(negedge clk);
            n++;
        end
        chk_eq("start_before_reset", drw_start, 1);
        #2 rst = 1;
        #1;
        chk_eq("async_start_drop", drw_start, 0);
        chk_eq("async_counters", {edges_drawn, edges_skipped, timeouts}, 0);
        chk_eq("async_ready", cmd_ready, 1);
        @(negedge clk);
        rst = 0;
        repeat (30) @(negedge clk);
        n = 0;
        while (drw_busy && n < 500) begin
            @(negedge clk);
            n++;
        end
        chk_eq("post_reset_idle", {busy, drw_start, fifo_level}, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
